// File: rtl/fifo_read_ctrl.sv
// Read-side pointer and flag controller for the async FIFO, clk_diff domain.
// Tracks the synchronized write pointer and produces the RAM read address, occupancy flags and the gray read pointer.
module fifo_read_ctrl #(
    parameter int LENGTH       = 8,
    parameter int ALMOST_EMPTY = 4
) (
    input  logic              clk_diff,
    input  logic              reset_diff_n,
    input  logic [LENGTH-1:0] wr_gray_synced,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              underflow_clear,
    output logic [LENGTH-2:0] rd_addr,
    output logic              rd_valid,
    output logic [LENGTH-1:0] rd_gray,
    output logic              empty,
    output logic              almost_empty,
    output logic [LENGTH-1:0] level,
    output logic              underflow,
    output logic              ptr_err
);

    localparam logic [LENGTH-1:0] DEPTH    = LENGTH'(1) << (LENGTH - 1);
    localparam logic [LENGTH-1:0] AE_LEVEL = LENGTH'(ALMOST_EMPTY);

    function automatic logic [LENGTH-1:0] gray2bin(input logic [LENGTH-1:0] g);
        logic [LENGTH-1:0] b;
        b[LENGTH-1] = g[LENGTH-1];
        for (int i = LENGTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [LENGTH-1:0] bin2gray(input logic [LENGTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [LENGTH-1:0] wr_gray_q, wr_gray_d;
    logic [LENGTH-1:0] wr_bin_q,  wr_bin_d;
    logic [LENGTH-1:0] rd_bin_q,  rd_bin_d;
    logic [LENGTH-1:0] rd_gray_q, rd_gray_d;
    logic [LENGTH-1:0] level_q,   level_d;
    logic              empty_q,   empty_d;
    logic              almost_empty_q, almost_empty_d;
    logic              rd_valid_q, rd_valid_d;
    logic              underflow_q, underflow_d;
    logic              ptr_err_q,  ptr_err_d;
    logic              pop;
    logic              underflow_set;
    logic              ptr_err_set;

    // Flags come from next-state pointers so a pop on this edge is already reflected;
    // the registered empty can therefore gate pop without a double pop of the last entry.
    always_comb begin
        pop           = rd_en & ~empty_q & ~flush;
        underflow_set = rd_en & empty_q & ~flush;

        wr_gray_d = wr_gray_synced;
        wr_bin_d  = gray2bin(wr_gray_q);

        if (flush) begin
            rd_bin_d = wr_bin_d;
        end else begin
            rd_bin_d = rd_bin_q + LENGTH'(pop);
        end

        rd_gray_d      = bin2gray(rd_bin_d);
        level_d        = wr_bin_d - rd_bin_d;
        empty_d        = (level_d == '0);
        almost_empty_d = (level_d <= AE_LEVEL);
        rd_valid_d     = pop;

        ptr_err_set = (level_d > DEPTH);

        underflow_d = underflow_q;
        if (underflow_clear) begin
            underflow_d = 1'b0;
        end
        if (underflow_set) begin
            underflow_d = 1'b1;
        end

        ptr_err_d = ptr_err_q;
        if (underflow_clear) begin
            ptr_err_d = 1'b0;
        end
        if (ptr_err_set) begin
            ptr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_diff) begin
        if (!reset_diff_n) begin
            wr_gray_q      <= '0;
            wr_bin_q       <= '0;
            rd_bin_q       <= '0;
            rd_gray_q      <= '0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            rd_valid_q     <= 1'b0;
            underflow_q    <= 1'b0;
            ptr_err_q      <= 1'b0;
        end else begin
            wr_gray_q      <= wr_gray_d;
            wr_bin_q       <= wr_bin_d;
            rd_bin_q       <= rd_bin_d;
            rd_gray_q      <= rd_gray_d;
            level_q        <= level_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            rd_valid_q     <= rd_valid_d;
            underflow_q    <= underflow_d;
            ptr_err_q      <= ptr_err_d;
        end
    end

    // wr_bin_q is kept as the registered stage-2 value; the datapath uses its next state.
    logic wr_bin_unused;
    assign wr_bin_unused = ^wr_bin_q;

    assign rd_addr      = rd_bin_q[LENGTH-2:0];
    assign rd_valid     = rd_valid_q;
    assign rd_gray      = rd_gray_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign level        = level_q;
    assign underflow    = underflow_q;
    assign ptr_err      = ptr_err_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: an 8-bit pointer instance for handshake/flag
// behaviour and a 4-bit pointer instance for wrap-around, full and corrupt-pointer cases.
module tb_fifo_read_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LENGTH = 8 instance
    logic       a_rst_n = 1'b0;
    logic [7:0] a_wr_gray = 8'h00;
    logic       a_rd_en = 1'b0, a_flush = 1'b0, a_uclr = 1'b0;
    logic [6:0] a_rd_addr;
    logic       a_rd_valid, a_empty, a_ae, a_underflow, a_ptr_err;
    logic [7:0] a_rd_gray, a_level;

    // LENGTH = 4 instance
    logic       b_rst_n = 1'b0;
    logic [3:0] b_wr_gray = 4'h0;
    logic       b_rd_en = 1'b0, b_flush = 1'b0, b_uclr = 1'b0;
    logic [2:0] b_rd_addr;
    logic       b_rd_valid, b_empty, b_ae, b_underflow, b_ptr_err;
    logic [3:0] b_rd_gray, b_level;

    int n_cmp = 0;
    int n_err = 0;

    fifo_read_ctrl #(.LENGTH(8), .ALMOST_EMPTY(4)) dut_a (
        .clk_diff(clk), .reset_diff_n(a_rst_n), .wr_gray_synced(a_wr_gray),
        .rd_en(a_rd_en), .flush(a_flush), .underflow_clear(a_uclr),
        .rd_addr(a_rd_addr), .rd_valid(a_rd_valid), .rd_gray(a_rd_gray),
        .empty(a_empty), .almost_empty(a_ae), .level(a_level),
        .underflow(a_underflow), .ptr_err(a_ptr_err)
    );

    fifo_read_ctrl #(.LENGTH(4), .ALMOST_EMPTY(4)) dut_b (
        .clk_diff(clk), .reset_diff_n(b_rst_n), .wr_gray_synced(b_wr_gray),
        .rd_en(b_rd_en), .flush(b_flush), .underflow_clear(b_uclr),
        .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_gray(b_rd_gray),
        .empty(b_empty), .almost_empty(b_ae), .level(b_level),
        .underflow(b_underflow), .ptr_err(b_ptr_err)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with a non-zero write pointer already present (gray 03 = bin 2)
        a_wr_gray = 8'h03;
        step(2);
        chk("rst_empty", a_empty, 1);
        chk("rst_level", a_level, 0);
        chk("rst_rd_gray", a_rd_gray, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_underflow", a_underflow, 0);
        chk("rst_ptr_err", a_ptr_err, 0);
        chk("rst_rd_addr", a_rd_addr, 0);

        a_rst_n = 1'b1;
        step(1);
        chk("rel1_level", a_level, 0);
        chk("rel1_empty", a_empty, 1);
        step(1);
        chk("rel2_level", a_level, 2);
        chk("rel2_empty", a_empty, 0);
        chk("rel2_ae", a_ae, 1);

        // Two pops, then a third rd_en against an empty FIFO
        a_rd_en = 1'b1;
        chk("pop_addr0", a_rd_addr, 0);
        step(1);
        chk("pop1_addr", a_rd_addr, 1);
        chk("pop1_valid", a_rd_valid, 1);
        chk("pop1_level", a_level, 1);
        step(1);
        chk("pop2_addr", a_rd_addr, 2);
        chk("pop2_valid", a_rd_valid, 1);
        chk("pop2_level", a_level, 0);
        chk("pop2_empty", a_empty, 1);
        chk("pop2_rd_gray", a_rd_gray, 8'h03);
        step(1);
        chk("pop3_valid", a_rd_valid, 0);
        chk("pop3_addr", a_rd_addr, 2);
        chk("uf_set", a_underflow, 1);
        chk("uf_level", a_level, 0);

        a_rd_en = 1'b0;
        a_uclr  = 1'b1;
        step(1);
        chk("uf_clear", a_underflow, 0);
        a_rd_en = 1'b1;
        step(1);
        chk("uf_set_wins", a_underflow, 1);
        chk("uf_set_addr", a_rd_addr, 2);
        a_rd_en = 1'b0;
        a_uclr  = 1'b0;

        // Write pointer to bin 8 (gray 0C): level 6, then flush together with rd_en
        a_wr_gray = 8'h0C;
        step(2);
        chk("l6_level", a_level, 6);
        chk("l6_ae", a_ae, 0);
        a_flush = 1'b1;
        a_rd_en = 1'b1;
        step(1);
        chk("flush_valid", a_rd_valid, 0);
        chk("flush_level", a_level, 0);
        chk("flush_empty", a_empty, 1);
        chk("flush_rd_gray", a_rd_gray, 8'h0C);
        chk("flush_addr", a_rd_addr, 8);
        chk("flush_no_uf", a_underflow, 1);
        a_flush = 1'b0;
        a_rd_en = 1'b0;

        // Write pointer to bin 13 (gray 0B): level 5, pop to 4 raises almost_empty
        a_wr_gray = 8'h0B;
        step(2);
        chk("l5_level", a_level, 5);
        chk("l5_ae", a_ae, 0);
        a_rd_en = 1'b1;
        step(1);
        chk("l4_level", a_level, 4);
        chk("l4_ae", a_ae, 1);
        chk("l4_valid", a_rd_valid, 1);
        a_rd_en = 1'b0;
        step(1);
        chk("idle_valid", a_rd_valid, 0);
        chk("idle_level", a_level, 4);

        // Mid-operation reset drops a pending rd_valid
        a_rd_en = 1'b1;
        step(1);
        chk("pre_rst_valid", a_rd_valid, 1);
        a_rst_n = 1'b0;
        step(1);
        chk("mid_rst_valid", a_rd_valid, 0);
        chk("mid_rst_level", a_level, 0);
        chk("mid_rst_empty", a_empty, 1);
        a_rd_en = 1'b0;

        // LENGTH = 4: full, wrap-around and corrupt pointer
        step(1);
        b_rst_n = 1'b1;
        b_wr_gray = 4'hC;  // bin 8
        step(2);
        chk("b_full_level", b_level, 8);
        chk("b_full_empty", b_empty, 0);
        chk("b_full_ptr_err", b_ptr_err, 0);
        b_flush = 1'b1;
        step(1);
        chk("b_flush_level", b_level, 0);
        chk("b_flush_gray", b_rd_gray, 4'hC);
        b_flush = 1'b0;

        b_wr_gray = 4'h8;  // bin 15
        step(2);
        chk("b_l7_level", b_level, 7);
        b_rd_en = 1'b1;
        step(7);
        b_rd_en = 1'b0;
        chk("b_rd15_gray", b_rd_gray, 4'b1000);
        chk("b_rd15_level", b_level, 0);
        chk("b_rd15_empty", b_empty, 1);
        chk("b_rd15_addr", b_rd_addr, 7);

        b_wr_gray = 4'h2;  // bin 3, wrapped past 15
        step(2);
        chk("b_wrap_level", b_level, 4);
        b_rd_en = 1'b1;
        step(1);
        b_rd_en = 1'b0;
        chk("b_wrap_gray", b_rd_gray, 4'b0000);
        chk("b_wrap_level2", b_level, 3);
        chk("b_wrap_addr", b_rd_addr, 0);
        chk("b_wrap_ptr_err", b_ptr_err, 0);

        b_wr_gray = 4'hA;  // bin 12 against rd 0: level 12 is impossible
        step(2);
        chk("b_err_level", b_level, 12);
        chk("b_err_set", b_ptr_err, 1);
        b_uclr = 1'b1;
        step(1);
        chk("b_err_set_wins", b_ptr_err, 1);
        b_uclr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
